layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised per-line layer compositor, generalising the fixed four-layer draw sequencing of the game top level.
- On request it renders one display line into the frame buffer. It walks NUM_LAYERS layers back to front and, for each layer, every X from 0 to H_ACTIVE-1.
- For each pixel it priority-selects one sprite source, fetches the packed sprite ROM word, unpacks the pixel index and writes it unless the pixel is transparent.
- Sits between the draw_* sprite address generators, the sprite ROM and frame_buffer.

Parameters:
NUM_SOURCES, 12, number of sprite sources (draw flag + address each)
NUM_LAYERS, 4, layer count; layer 0 is the opaque background layer
LAYER_W, 2, width of layer index (clog2 NUM_LAYERS)
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, valid line count
SRC_ADDR_W, 18, pixel-granular sprite address width
PIX_W, 4, bits per colour index
WORD_W, 16, ROM word width; WORD_W/PIX_W must be a power of two
ROM_LAT, 1, ROM read latency in cycles (1..4)
BG_INDEX, 4, colour index written on layer 0 where nothing opaque hits

Ports:
Clk50  in  1  system clock
Reset  in  1  asynchronous, active-low reset
line_req  in  1  single-cycle render request
line_y  in  10  line to render, sampled with line_req
busy  out  1  render in progress
line_done  out  1  one-cycle completion pulse
overrun  out  1  sticky: line_req arrived while busy
WriteX  out  10  X currently being issued (drives sources)
WriteY  out  10  line being rendered (drives sources)
write_layer  out  LAYER_W  layer currently being issued
src_draw  in  NUM_SOURCES  per-source hit at (WriteX, WriteY), combinational
src_layer  in  NUM_SOURCES*LAYER_W  layer of each source
src_addr  in  NUM_SOURCES*SRC_ADDR_W  pixel address per source
rom_addr  out  SRC_ADDR_W-clog2(WORD_W/PIX_W)  registered ROM word address
rom_q  in  WORD_W  ROM data
fb_we  out  1  frame-buffer write enable
fb_x  out  10  write X
fb_y  out  10  write Y
fb_data  out  PIX_W  colour index
fb_select  out  1  equals fb_y[0]

Behaviour:
- Reset (async, Reset=0):
  - All outputs are 0; FSM goes to IDLE; pipeline valid bits clear.
  - Reset mid-line aborts the line: no further fb_we and no line_done.
- FSM IDLE -> RUN:
  - On line_req with line_y < V_ACTIVE: latch WriteY=line_y, layer=0, X=0; busy=1 from the next cycle.
  - On line_req with line_y >= V_ACTIVE: no writes, no busy; line_done pulses in the next cycle.
- RUN:
  - One pixel is issued per cycle; X increments.
  - At X=H_ACTIVE-1, X wraps to 0 and the layer increments.
  - After the last pixel of layer NUM_LAYERS-1 the FSM goes to DRAIN.
- DRAIN:
  - Waits until the pipeline is empty (L=ROM_LAT+2 cycles after the last issue).
  - Pulses line_done and drops busy in the same cycle, then returns to IDLE.
  - A line_req in that cycle is accepted.
- line_req while busy=1: the request is ignored and overrun is set (cleared only by Reset).
- Source select for pixel issued at cycle t: lowest index i with src_draw[i]=1 and src_layer[i]==write_layer. If no source matches, hit=0.
- Pipeline timing:
  - rom_addr = selected src_addr >> clog2(WORD_W/PIX_W), valid during t+1.
  - rom_q valid during t+1+ROM_LAT.
  - Sideband (x, y, layer, hit, sub-index) travels in a matched shift register.
  - fb_* are registered; the write appears in cycle t+2+ROM_LAT.
- Unpack: k = src_addr mod (WORD_W/PIX_W); pixel = rom_q[WORD_W-1-k*PIX_W -: PIX_W]. For the defaults, k=0 selects [15:12].
- Transparency: pixel index 0 is transparent.
- Write rules:
  - Layer 0: fb_we=1 for every pixel; fb_data=pixel if hit and pixel!=0, else BG_INDEX.
  - Layers >0: fb_we=1 only if hit and pixel!=0.
- Throughput is exactly NUM_LAYERS*H_ACTIVE issue cycles plus L drain cycles per line (2563 with defaults).

Decomposition:
- compositor_pkg holds:
  - the pipeline sideband struct typedef (x, y, layer, hit, sub-index);
  - the unpack function;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the transparent index constant 0.
- Sub-module comp_src_select: combinational priority encoder plus address mux over NUM_SOURCES, parametrised on LAYER_W/SRC_ADDR_W.

Test Plan:
- Empty scene, line_y=10, all src_draw=0 -> 640 writes on layer 0 with fb_data=4, none on layers 1-3; line_done exactly 2563 cycles after acceptance; fb_select=0.
- Source 3 on layer 2 hits X=100..131 with rom_q word 0x1230, addresses 4n..4n+3 -> writes with data 1,2,3 at X≡0,1,2 (mod 4), no write at X≡3; each write appears ROM_LAT+2 cycles after issue.
- Sources 2 and 5 both on layer 1 hitting X=50 -> source 2's address appears on rom_addr; source 5 is never fetched.
- line_req pulsed mid-line -> ignored, overrun=1 and held; the next line_req in the line_done cycle is accepted, busy stays 1.
- Reset=0 at X=300 of layer 1 -> fb_we=0 the same cycle and after; busy=0, no line_done; line_y=480 request -> line_done next cycle with no writes.
- ROM_LAT=3 rebuild, repeat scenario 2 -> identical written data, latency 5 cycles.

Source files
------------

// File: rtl/compositor_pkg.sv
// compositor_pkg: FSM state, pipeline sideband record, transparent index and pixel unpack helper
package compositor_pkg;
  localparam int TRANSPARENT = 0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] layer;
    logic       hit;
    logic [3:0] sub;
  } sideband_t;
  // Pixels are packed MSB-first: sub-index k=0 is the top pix_w bits of the word.
  function automatic logic [7:0] unpack(input logic [63:0] word, input int word_w, input int pix_w, input logic [3:0] k);
    return 8'(word >> (word_w - (int'(k) + 1) * pix_w)) & 8'((1 << pix_w) - 1);
  endfunction
endpackage

// File: rtl/comp_src_select.sv
// comp_src_select: priority select of the lowest-index drawing source on the requested layer
// ports: draw/layers/addrs packed per source, layer to match; hit and the winning address out
module comp_src_select #(
  parameter int NUM_SOURCES = 12,
  parameter int LAYER_W = 2,
  parameter int SRC_ADDR_W = 18
) (
  input  logic [NUM_SOURCES-1:0]            draw,
  input  logic [NUM_SOURCES*LAYER_W-1:0]    layers,
  input  logic [NUM_SOURCES*SRC_ADDR_W-1:0] addrs,
  input  logic [LAYER_W-1:0]                layer,
  output logic                              hit,
  output logic [SRC_ADDR_W-1:0]             addr
);
  // Scanning downwards lets the lowest matching index overwrite last.
  always_comb begin
    hit = 1'b0;
    addr = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (draw[i] && layers[i*LAYER_W +: LAYER_W] == layer) begin
        hit = 1'b1;
        addr = addrs[i*SRC_ADDR_W +: SRC_ADDR_W];
      end
  end
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: renders one display line, layer by layer back to front, into the frame buffer
// ports: Clk50/Reset (async active-low); line_req/line_y request, busy/line_done/overrun status;
//        WriteX/WriteY/write_layer drive the sources, src_* return hits; rom_addr/rom_q sprite ROM;
//        fb_* registered frame-buffer write port
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_SOURCES = 12,
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SRC_ADDR_W = 18,
  parameter int PIX_W = 4,
  parameter int WORD_W = 16,
  parameter int ROM_LAT = 1,
  parameter int BG_INDEX = 4,
  localparam int PPW = WORD_W / PIX_W,
  localparam int SH = $clog2(PPW),
  localparam int RA_W = SRC_ADDR_W - SH
) (
  input  logic                              Clk50,
  input  logic                              Reset,
  input  logic                              line_req,
  input  logic [9:0]                        line_y,
  output logic                              busy,
  output logic                              line_done,
  output logic                              overrun,
  output logic [9:0]                        WriteX,
  output logic [9:0]                        WriteY,
  output logic [LAYER_W-1:0]                write_layer,
  input  logic [NUM_SOURCES-1:0]            src_draw,
  input  logic [NUM_SOURCES*LAYER_W-1:0]    src_layer,
  input  logic [NUM_SOURCES*SRC_ADDR_W-1:0] src_addr,
  output logic [RA_W-1:0]                   rom_addr,
  input  logic [WORD_W-1:0]                 rom_q,
  output logic                              fb_we,
  output logic [9:0]                        fb_x,
  output logic [9:0]                        fb_y,
  output logic [PIX_W-1:0]                  fb_data,
  output logic                              fb_select
);
  state_t state, state_n;
  logic [9:0] x, y;
  logic [LAYER_W-1:0] layer;
  logic [2:0] dcnt;
  logic bad_done, accept, line_ok, issue, x_last, last_pix, drain_end, sel_hit, opaque;
  logic [SRC_ADDR_W-1:0] sel_addr;
  logic [ROM_LAT:0] vld;
  sideband_t sb [ROM_LAT+1];
  logic [PIX_W-1:0] pix;

  comp_src_select #(.NUM_SOURCES(NUM_SOURCES), .LAYER_W(LAYER_W), .SRC_ADDR_W(SRC_ADDR_W)) u_sel (
    .draw(src_draw), .layers(src_layer), .addrs(src_addr), .layer(layer), .hit(sel_hit), .addr(sel_addr)
  );

  assign WriteX = x;
  assign WriteY = y;
  assign write_layer = layer;
  assign issue = state == RUN;
  assign x_last = x == 10'(H_ACTIVE - 1);
  assign last_pix = x_last && layer == LAYER_W'(NUM_LAYERS - 1);
  // The last write leaves the pipeline ROM_LAT+2 cycles after the final issue.
  assign drain_end = state == DRAIN && dcnt == 3'(ROM_LAT + 1);
  assign accept = line_req && !busy;
  assign line_ok = line_y < 10'(V_ACTIVE);

  always_ff @(posedge Clk50 or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (accept) state_n = line_ok ? RUN : IDLE;
    else if (issue && last_pix) state_n = DRAIN;
    else if (drain_end) state_n = IDLE;
  end

  // busy drops in the line_done cycle so a back-to-back request is accepted there.
  always_comb begin
    busy = issue || (state == DRAIN && !drain_end);
    line_done = drain_end || bad_done;
  end

  always_ff @(posedge Clk50 or negedge Reset)
    if (!Reset) begin
      x <= '0;
      y <= '0;
      layer <= '0;
      dcnt <= '0;
      bad_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      bad_done <= accept && !line_ok;
      overrun <= overrun || (line_req && busy);
      dcnt <= state == DRAIN ? dcnt + 3'd1 : 3'd0;
      if (accept && line_ok) begin
        y <= line_y;
        x <= '0;
        layer <= '0;
      end else if (issue) begin
        x <= x_last ? 10'd0 : x + 10'd1;
        layer <= x_last ? layer + 1'b1 : layer;
      end
    end

  // Sideband shifts alongside the ROM so sb[ROM_LAT] lines up with rom_q.
  always_ff @(posedge Clk50 or negedge Reset)
    if (!Reset) begin
      vld <= '0;
      rom_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) sb[i] <= '0;
    end else begin
      vld <= {vld[ROM_LAT-1:0], issue};
      sb[0] <= '{x: x, y: y, layer: 4'(layer), hit: sel_hit && issue, sub: 4'(sel_addr % PPW)};
      for (int i = 1; i <= ROM_LAT; i++) sb[i] <= sb[i-1];
      if (issue) rom_addr <= RA_W'(sel_addr >> SH);
    end

  assign pix = PIX_W'(unpack(64'(rom_q), WORD_W, PIX_W, sb[ROM_LAT].sub));
  assign opaque = sb[ROM_LAT].hit && pix != PIX_W'(TRANSPARENT);

  always_ff @(posedge Clk50 or negedge Reset)
    if (!Reset) begin
      fb_we <= 1'b0;
      fb_x <= '0;
      fb_y <= '0;
      fb_data <= '0;
      fb_select <= 1'b0;
    end else begin
      fb_we <= vld[ROM_LAT] && (opaque || sb[ROM_LAT].layer == 4'd0);
      if (vld[ROM_LAT]) begin
        fb_x <= sb[ROM_LAT].x;
        fb_y <= sb[ROM_LAT].y;
        fb_select <= sb[ROM_LAT].y[0];
        fb_data <= opaque ? pix : PIX_W'(BG_INDEX);
      end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed checks of two compositors (ROM latency 1 and 3) sharing one request stream
module tb_layer_compositor;
  logic clk = 1'b0, rst_n = 1'b0, line_req = 1'b0;
  logic [9:0] line_y = '0;
  int scene = 0;
  int checks = 0, errors = 0;

  logic busy_a, done_a, ovr_a, we_a, fs_a, busy_b, done_b, ovr_b, we_b, fs_b;
  logic [9:0] wx_a, wy_a, fx_a, fy_a, wx_b, wy_b, fx_b, fy_b;
  logic [1:0] wl_a, wl_b;
  logic [3:0] fd_a, fd_b;
  logic [11:0] draw_a, draw_b;
  logic [23:0] lay;
  logic [215:0] addr_a, addr_b;
  logic [15:0] ra_a, ra_b, q_a, q_b;
  logic [15:0] qb [1:3];

  always #5 clk = ~clk;

  function automatic logic [11:0] f_draw(int sc, logic [9:0] x);
    logic [11:0] d = '0;
    if (sc == 1) begin
      d[3] = x >= 100 && x <= 131;
      d[0] = x >= 200 && x <= 203;
    end
    if (sc == 2) begin
      d[2] = x == 50;
      d[5] = x == 50;
    end
    return d;
  endfunction

  function automatic logic [23:0] f_lay(int sc);
    logic [23:0] l = '0;
    if (sc == 1) l[7:6] = 2'd2;
    if (sc == 2) begin
      l[5:4] = 2'd1;
      l[11:10] = 2'd1;
    end
    return l;
  endfunction

  function automatic logic [215:0] f_addr(logic [9:0] x);
    logic [215:0] a = '0;
    a[0 +: 18] = 18'(200 + int'(x));
    a[36 +: 18] = 18'd1000;
    a[54 +: 18] = 18'(300 + int'(x));
    a[90 +: 18] = 18'd2004;
    return a;
  endfunction

  function automatic logic [15:0] f_rom(logic [15:0] a);
    if (a >= 100 && a <= 107) return 16'h1230;
    if (a == 250) return 16'h7000;
    if (a == 501) return 16'h5000;
    return 16'h9999;
  endfunction

  // expected {we, data} for a pixel issued on layer ly at x
  function automatic logic [4:0] f_exp(int sc, int ly, int x);
    if (ly == 0) return (sc == 1 && x >= 200 && x <= 202) ? {1'b1, 4'(x - 199)} : {1'b1, 4'd4};
    if (ly == 1 && sc == 2 && x == 50) return {1'b1, 4'd7};
    if (ly == 2 && sc == 1 && x >= 100 && x <= 131 && x % 4 != 3) return {1'b1, 4'(x % 4 + 1)};
    return 5'd0;
  endfunction

  assign draw_a = f_draw(scene, wx_a);
  assign draw_b = f_draw(scene, wx_b);
  assign lay = f_lay(scene);
  assign addr_a = f_addr(wx_a);
  assign addr_b = f_addr(wx_b);
  assign q_b = qb[3];

  always @(posedge clk) begin
    q_a <= f_rom(ra_a);
    qb[1] <= f_rom(ra_b);
    qb[2] <= qb[1];
    qb[3] <= qb[2];
  end

  layer_compositor u_a (
    .Clk50(clk), .Reset(rst_n), .line_req(line_req), .line_y(line_y), .busy(busy_a), .line_done(done_a),
    .overrun(ovr_a), .WriteX(wx_a), .WriteY(wy_a), .write_layer(wl_a), .src_draw(draw_a), .src_layer(lay),
    .src_addr(addr_a), .rom_addr(ra_a), .rom_q(q_a), .fb_we(we_a), .fb_x(fx_a), .fb_y(fy_a), .fb_data(fd_a),
    .fb_select(fs_a)
  );

  layer_compositor #(.ROM_LAT(3)) u_b (
    .Clk50(clk), .Reset(rst_n), .line_req(line_req), .line_y(line_y), .busy(busy_b), .line_done(done_b),
    .overrun(ovr_b), .WriteX(wx_b), .WriteY(wy_b), .write_layer(wl_b), .src_draw(draw_b), .src_layer(lay),
    .src_addr(addr_b), .rom_addr(ra_b), .rom_q(q_b), .fb_we(we_b), .fb_x(fx_b), .fb_y(fy_b), .fb_data(fd_b),
    .fb_select(fs_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // n counts negedges after the request cycle: issue i is seen at n=i+1, its write at n=i+lat+3
  task automatic cyc(string t, int lat, int n, int sc, logic [9:0] y, bit valid, int done_n,
                     logic busy, logic done, logic we, logic [9:0] wx, logic [1:0] wl,
                     logic [9:0] fx, logic [9:0] fy, logic [3:0] fd, logic fs);
    int i = n - lat - 3;
    logic [4:0] e = (valid && i >= 0 && i < 2560) ? f_exp(sc, i / 640, i % 640) : 5'd0;
    chk({t, " fb_we"}, we, e[4]);
    if (e[4]) begin
      chk({t, " fb_data"}, fd, e[3:0]);
      chk({t, " fb_x"}, fx, i % 640);
      chk({t, " fb_y"}, fy, y);
      chk({t, " fb_select"}, fs, y[0]);
    end
    chk({t, " line_done"}, done, n == done_n);
    if (valid && n <= 2560) begin
      chk({t, " WriteX"}, wx, (n - 1) % 640);
      chk({t, " write_layer"}, wl, (n - 1) / 640);
      chk({t, " busy run"}, busy, 1);
    end
    if (!valid) chk({t, " busy idle"}, busy, 0);
  endtask

  typedef struct {
    int sc;
    logic [9:0] y;
    int nw;
    int sum;
    int da;
    int db;
  } vec_t;
  vec_t tv [4];

  initial begin
    int got, bad, nwa, suma, nwb, sumb;
    bit s250a, s501a, s250b, s501b;
    tv[0] = '{0, 10'd10, 640, 2560, 2563, 2565};
    tv[1] = '{1, 10'd11, 664, 2602, 2563, 2565};
    tv[2] = '{2, 10'd479, 641, 2567, 2563, 2565};
    tv[3] = '{0, 10'd480, 0, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst busy", busy_a, 0);
    chk("rst line_done", done_a, 0);
    chk("rst overrun", ovr_a, 0);
    chk("rst fb_we", we_a, 0);
    chk("rst WriteX", wx_a, 0);
    chk("rst rom_addr", ra_a, 0);
    chk("rst fb_data", fd_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // request while busy is ignored and sets the sticky overrun
    line_y = 10'd5;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    repeat (99) @(negedge clk);
    chk("ovr before", ovr_a, 0);
    line_y = 10'd7;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("ovr set", ovr_a, 1);
    chk("ovr busy", busy_a, 1);
    chk("ovr WriteY kept", wy_a, 5);
    got = 0;
    for (int k = 0; k < 3000 && got == 0; k++) begin
      @(negedge clk);
      got = done_a;
    end
    chk("ovr done seen", got, 1);
    chk("ovr held", ovr_a, 1);
    // request in the line_done cycle is accepted
    line_y = 10'd20;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    chk("b2b busy", busy_a, 1);
    chk("b2b WriteY", wy_a, 20);

    // abort at layer 1, X=300
    repeat (940) @(negedge clk);
    chk("abort WriteX", wx_a, 300);
    chk("abort layer", wl_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort fb_we", we_a, 0);
    chk("abort busy", busy_a, 0);
    chk("abort overrun", ovr_a, 0);
    chk("abort WriteX rst", wx_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad += int'(done_a) + int'(we_a) + int'(busy_a) + int'(done_b) + int'(we_b);
    end
    chk("abort quiet", bad, 0);

    for (int v = 0; v < 4; v++) begin
      scene = tv[v].sc;
      line_y = tv[v].y;
      line_req = 1'b1;
      {nwa, suma, nwb, sumb} = '0;
      {s250a, s501a, s250b, s501b} = '0;
      for (int n = 1; n <= 2570; n++) begin
        @(negedge clk);
        line_req = 1'b0;
        cyc("A", 1, n, scene, tv[v].y, tv[v].y < 480, tv[v].da, busy_a, done_a, we_a, wx_a, wl_a, fx_a, fy_a, fd_a, fs_a);
        cyc("B", 3, n, scene, tv[v].y, tv[v].y < 480, tv[v].db, busy_b, done_b, we_b, wx_b, wl_b, fx_b, fy_b, fd_b, fs_b);
        if (we_a) begin nwa++; suma += int'(fd_a); end
        if (we_b) begin nwb++; sumb += int'(fd_b); end
        s250a |= ra_a == 16'd250;
        s501a |= ra_a == 16'd501;
        s250b |= ra_b == 16'd250;
        s501b |= ra_b == 16'd501;
      end
      chk("A write count", nwa, tv[v].nw);
      chk("A write sum", suma, tv[v].sum);
      chk("B write count", nwb, tv[v].nw);
      chk("B write sum", sumb, tv[v].sum);
      chk("A overrun clear", ovr_a, 0);
      if (tv[v].sc == 2) begin
        chk("A src2 fetched", s250a, 1);
        chk("A src5 fetched", s501a, 0);
        chk("B src2 fetched", s250b, 1);
        chk("B src5 fetched", s501b, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
